nbcac_20di_decode_arbiter: RTL and testbench
============================================

Name: nbcac_20di_decode_arbiter

Overview:
- Shares one combinational 29-to-20 NBCAC decoder core (nbcac_20di_decoder_core) among NCH requester channels.
- Each channel presents a 29-bit NBCAC codeword with a valid/ready handshake.
- A round-robin arbiter grants one channel per cycle into a 2-stage pipeline: capture register, then decode into the output register.
- The output carries the decoded 20-bit value and the source channel ID. Sits between the bus receivers and the consumer of decoded data.

Parameters:
- NCH, 4, number of requester channels, 2..8.
- IDW, 2, width of channel ID; must satisfy 2^IDW >= NCH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NCH  channel i has a codeword.
- req_ready  out  NCH  channel i codeword accepted this cycle.
- req_data  in  NCH*29  channel i codeword in bits [29*i+28:29*i]; bit 29*i+k = d[k+1].
- out_valid  out  1  decoded word available.
- out_ready  in  1  consumer accepts.
- out_data  out  20  decoded value.
- out_id  out  IDW  channel that supplied the word.

Behaviour:
- Reset, asynchronous, active-high; all of the following cleared:
  - out_valid=0, out_data=0, out_id=0.
  - s1_valid=0, s1 data and ID = 0.
  - Round-robin pointer ptr=0.
  - req_ready=0 while rst is high.
  - In-flight words are discarded. No partial handshake survives reset.
- Pipeline enables:
  - s2_en = !out_valid | out_ready.
  - s1_en = !s1_valid | s2_en.
- Arbitration (combinational):
  - Only when s1_en=1.
  - Search req_valid starting at index ptr, ascending, wrapping NCH-1 -> 0.
  - The first set index g is granted: req_ready[g]=1, all other req_ready bits 0.
  - If s1_en=0 or no valid request, req_ready is all 0.
  - At most one req_ready bit is ever high.
- On grant, at the clock edge:
  - s1_data <= codeword of channel g; s1_id <= g; s1_valid <= 1.
  - ptr <= (g+1) mod NCH.
  - If no grant, ptr holds.
  - If s1_en=1 and no grant, s1_valid <= 0.
- Stage 2, at the clock edge when s2_en=1:
  - out_data <= decode(s1_data); out_id <= s1_id; out_valid <= s1_valid.
  - When s2_en=0, the out_* registers hold steady.
  - out_data and out_id must not change while out_valid=1 and out_ready=0.
- decode():
  - Weighted sum of codeword bits with weights, for d[1..29]: 1, 635622, 392836, 242786, 150050, 92736, 57314, 35422, 21892, 13530, 8362, 5168, 3194, 1974, 1220, 754, 466, 288, 178, 110, 68, 42, 26, 16, 10, 6, 4, 2, 2.
  - Result is truncated to 20 bits (mod 2^20), matching the core. No overflow flag.
- Latency and throughput:
  - Accept edge at cycle T gives out_valid=1 from cycle T+2 when unstalled.
  - Sustained throughput is 1 word/cycle with out_ready held high.
- Backpressure:
  - out_ready low with both stages full: req_ready goes all 0 in that cycle.
  - Accepted words are never dropped or duplicated.
- Fairness: a channel holding req_valid is granted within NCH accepting cycles.
- Data stability: req_data is sampled only in the cycle its req_ready is high.
- Out-of-range indices: indices >= NCH are never granted when NCH is not a power of 2.

Test Plan:
- Reset, then single channel 0 sends 29'h0000002 -> req_ready[0] in the same cycle; two cycles later out_valid=1, out_data=635622, out_id=0.
- Channel 1 sends 29'h0000007, then 29'h000000E -> out_data=1028459, then out_data=222668 (truncated mod 2^20), both with out_id=1 on consecutive cycles.
- All 4 channels valid continuously, out_ready=1 -> grants 0,1,2,3,0,… one per cycle; out_id follows the same order, 1 word/cycle.
- out_ready low for 5 cycles with all channels valid -> after the pipeline fills, req_ready all 0; out_data/out_id stable; on release, no loss or duplication (sequence check).
- Only channels 2 and 3 valid, ptr=0 -> grants alternate 2,3,2,3.
- Assert rst while both stages are full and a request is pending -> out_valid=0, out_data=0, out_id=0, req_ready=0 immediately; after release, the first grant is channel 0 if valid.

Source files
------------

// File: rtl/nbcac_20di_decode_arbiter.sv
// nbcac_20di_decode_arbiter: round-robin sharing of one NBCAC 29-to-20 decoder among NCH channels
module nbcac_20di_decoder_core (
    input  logic [28:0] code,
    output logic [19:0] value
);
    localparam logic [19:0] W [0:28] = '{
        20'd1,      20'd635622, 20'd392836, 20'd242786, 20'd150050, 20'd92736,
        20'd57314,  20'd35422,  20'd21892,  20'd13530,  20'd8362,   20'd5168,
        20'd3194,   20'd1974,   20'd1220,   20'd754,    20'd466,    20'd288,
        20'd178,    20'd110,    20'd68,     20'd42,     20'd26,     20'd16,
        20'd10,     20'd6,      20'd4,      20'd2,      20'd2
    };
    // weighted sum of set codeword bits, wrapping mod 2^20
    always_comb begin
        value = '0;
        for (int k = 0; k < 29; k++)
            value = value + (code[k] ? W[k] : 20'd0);
    end
endmodule

module nbcac_20di_decode_arbiter #(
    parameter int NCH = 4,
    parameter int IDW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    req_valid,
    output logic [NCH-1:0]    req_ready,
    input  logic [NCH*29-1:0] req_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [19:0]       out_data,
    output logic [IDW-1:0]    out_id
);
    logic           s1_valid, s1_en, s2_en, found, grant;
    logic [28:0]    s1_data, cw;
    logic [IDW-1:0] s1_id, ptr, g;
    logic [19:0]    dec;

    assign s2_en = !out_valid || out_ready;
    assign s1_en = !s1_valid || s2_en;
    assign grant = found && s1_en && !rst;
    assign req_ready = grant ? (NCH'(1) << g) : '0;

    // lowest valid index at or above ptr wins, otherwise wrap to lowest valid index
    always_comb begin
        found = 1'b0;
        g = '0;
        cw = '0;
        for (int j = NCH - 1; j >= 0; j--)
            if (req_valid[j]) begin
                found = 1'b1;
                g = IDW'(j);
            end
        for (int j = NCH - 1; j >= 0; j--)
            if (req_valid[j] && IDW'(j) >= ptr)
                g = IDW'(j);
        for (int j = 0; j < NCH; j++)
            if (IDW'(j) == g)
                cw = req_data[29*j +: 29];
    end

    nbcac_20di_decoder_core u_core (
        .code  (s1_data),
        .value (dec)
    );

    // capture stage: latch the granted codeword and move the pointer past the winner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_id    <= '0;
            ptr      <= '0;
        end else if (s1_en) begin
            s1_valid <= grant;
            if (grant) begin
                s1_data <= cw;
                s1_id   <= g;
                ptr     <= (g == IDW'(NCH - 1)) ? '0 : g + 1'b1;
            end
        end
    end

    // output stage: decode into the output register unless the consumer is stalling
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else if (s2_en) begin
            out_valid <= s1_valid;
            out_data  <= dec;
            out_id    <= s1_id;
        end
    end
endmodule

// File: tb/tb_nbcac_20di_decode_arbiter.sv
// tb_nbcac_20di_decode_arbiter: directed and randomized checks against a behavioural model
module tb_nbcac_20di_decode_arbiter;
    localparam int NCH = 4;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    req_valid;
    logic [NCH-1:0]    req_ready;
    logic [NCH*29-1:0] req_data;
    logic              out_valid;
    logic              out_ready;
    logic [19:0]       out_data;
    logic [IDW-1:0]    out_id;

    nbcac_20di_decode_arbiter #(.NCH(NCH), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int val;
    } ent_t;

    ent_t           q[$];
    int             m_ptr;
    bit             m_s1_v, m_out_v;
    logic [NCH-1:0] last_rdy;
    int             n_checks = 0;
    int             n_errors = 0;

    int wts[29] = '{1, 635622, 392836, 242786, 150050, 92736, 57314, 35422, 21892,
                    13530, 8362, 5168, 3194, 1974, 1220, 754, 466, 288, 178, 110,
                    68, 42, 26, 16, 10, 6, 4, 2, 2};

    function automatic int ref_decode(logic [28:0] c);
        longint s = 0;
        for (int k = 0; k < 29; k++)
            if (c[k]) s += wts[k];
        return int'(s % 1048576);
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ptr = 0;
        m_s1_v = 0;
        m_out_v = 0;
    endtask

    task automatic set_ch(int ch, bit v, logic [28:0] c);
        req_valid[ch] = v;
        req_data[29*ch +: 29] = c;
    endtask

    task automatic step();
        int g;
        bit s2en, s1en;
        logic [NCH-1:0] er;
        ent_t e;
        #1;
        s2en = !m_out_v || out_ready;
        s1en = !m_s1_v || s2en;
        g = -1;
        if (s1en)
            for (int j = 0; j < NCH; j++)
                if (g < 0 && req_valid[(m_ptr + j) % NCH])
                    g = (m_ptr + j) % NCH;
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check("req_ready", req_ready, er);
        check("out_valid", out_valid, m_out_v);
        if (m_out_v && q.size() != 0) begin
            check("out_data", out_data, q[0].val);
            check("out_id", out_id, q[0].id);
        end
        last_rdy = req_ready;
        @(posedge clk);
        if (m_out_v && out_ready) void'(q.pop_front());
        if (g >= 0) begin
            e.id = g;
            e.val = ref_decode(req_data[29*g +: 29]);
            q.push_back(e);
            m_ptr = (g + 1) % NCH;
        end
        if (s2en) m_out_v = m_s1_v;
        if (s1en) m_s1_v = (g >= 0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_id", out_id, 0);
        check("rst_req_ready", req_ready, 0);
        set_ch(0, 1, 29'h1);
        #1;
        check("rst_ready_masked", req_ready, 0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;

        set_ch(0, 1, 29'h0000002);
        step();
        check("t1_ready", last_rdy, 4'b0001);
        set_ch(0, 0, '0);
        step();
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data, 635622);
        check("t1_id", out_id, 0);
        step();

        set_ch(1, 1, 29'h0000007);
        step();
        set_ch(1, 1, 29'h000000E);
        step();
        set_ch(1, 0, '0);
        check("t2a_data", out_data, 1028459);
        check("t2a_id", out_id, 1);
        step();
        check("t2b_data", out_data, 222668);
        check("t2b_id", out_id, 1);
        step();

        do_reset();
        for (int i = 0; i < NCH; i++) set_ch(i, 1, 29'($urandom));
        for (int i = 0; i < 12; i++) begin
            for (int c = 0; c < NCH; c++) req_data[29*c +: 29] = 29'($urandom);
            step();
            check("rr_order", last_rdy, 4'b0001 << (i % 4));
        end

        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            logic [19:0] hd;
            logic [IDW-1:0] hi;
            hd = out_data;
            hi = out_id;
            step();
            check("stall_ready", last_rdy, 0);
            check("stall_data", out_data, hd);
            check("stall_id", out_id, hi);
        end
        out_ready = 1'b1;
        repeat (8) step();

        do_reset();
        req_valid = '0;
        set_ch(2, 1, 29'h15);
        set_ch(3, 1, 29'h2A);
        for (int i = 0; i < 4; i++) begin
            step();
            check("alt23", last_rdy, (i % 2) ? 4'b1000 : 4'b0100);
        end

        req_valid = '1;
        out_ready = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_out_id", out_id, 0);
        check("arst_req_ready", req_ready, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        out_ready = 1'b1;
        step();
        check("post_rst_grant", last_rdy, 4'b0001);

        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < NCH; c++) set_ch(c, 1'($urandom_range(0, 1)), 29'($urandom));
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        req_valid = '0;
        out_ready = 1'b1;
        repeat (4) step();
        check("sb_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
